text_cursor_ctrl: RTL

- Keystroke-to-grid write controller sitting directly upstream of the text_editor character BRAM.
- Accepts ASCII key codes over a valid/ready handshake and tracks a cursor position.
- Drives text_editor's te_write_en / te_addr / te_input to place characters, erase them and clear the screen.
- Exports the cursor position for the renderer's cursor overlay.

---
 rtl/text_cursor_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/text_cursor_ctrl.sv
// Keystroke-to-grid write controller: decodes ASCII keys into cursor moves and
// single-cycle character writes for the text_editor BRAM, plus a full-screen clear.
module text_cursor_ctrl #(
    parameter int          SCREEN_WIDTH  = 76,
    parameter int          SCREEN_HEIGHT = 42,
    parameter logic [7:0]  BLANK_CHAR    = 8'h20,
    localparam int         AW = $clog2(SCREEN_WIDTH * SCREEN_HEIGHT),
    localparam int         XW = $clog2(SCREEN_WIDTH),
    localparam int         YW = $clog2(SCREEN_HEIGHT)
) (
    input  logic          pixel_clk_in,
    input  logic          rst_in,
    input  logic          key_valid_in,
    input  logic [7:0]    key_in,
    output logic          key_ready_out,
    output logic          te_write_en,
    output logic [AW-1:0] te_addr,
    output logic [7:0]    te_input,
    output logic [XW-1:0] cursor_x_out,
    output logic [YW-1:0] cursor_y_out,
    output logic          busy_out
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [XW-1:0] X_MAX     = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_MAX     = YW'(SCREEN_HEIGHT - 1);
    localparam logic [AW-1:0] ADDR_LAST = AW'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);

    state_t        state_q, state_d;
    logic [XW-1:0] cx_q, cx_d;
    logic [YW-1:0] cy_q, cy_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic [AW-1:0] cur_addr;
    logic          accept;

    assign cur_addr = AW'(cy_q) * AW'(SCREEN_WIDTH) + AW'(cx_q);
    assign accept   = key_valid_in && ready_q;

    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        case (state_q)
            IDLE: begin
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (accept) begin
                    if (key_in >= 8'h20 && key_in <= 8'h7E) begin
                        we_d   = 1'b1;
                        addr_d = cur_addr;
                        data_d = key_in;
                        if (cx_q == X_MAX) begin
                            cx_d = '0;
                            cy_d = (cy_q == Y_MAX) ? '0 : cy_q + 1'b1;
                        end else begin
                            cx_d = cx_q + 1'b1;
                        end
                    end else begin
                        case (key_in)
                            8'h08: begin
                                // Row-major layout makes the previous cell simply cur_addr-1.
                                if (cx_q != '0 || cy_q != '0) begin
                                    we_d   = 1'b1;
                                    addr_d = cur_addr - 1'b1;
                                    data_d = BLANK_CHAR;
                                    if (cx_q == '0) begin
                                        cx_d = X_MAX;
                                        cy_d = cy_q - 1'b1;
                                    end else begin
                                        cx_d = cx_q - 1'b1;
                                    end
                                end
                            end
                            8'h0D: begin
                                cx_d = '0;
                                cy_d = (cy_q == Y_MAX) ? '0 : cy_q + 1'b1;
                            end
                            8'h11: if (cx_q != '0)   cx_d = cx_q - 1'b1;
                            8'h12: if (cx_q != X_MAX) cx_d = cx_q + 1'b1;
                            8'h13: if (cy_q != '0)   cy_d = cy_q - 1'b1;
                            8'h14: if (cy_q != Y_MAX) cy_d = cy_q + 1'b1;
                            8'h0C: begin
                                state_d = CLEAR;
                                ready_d = 1'b0;
                                busy_d  = 1'b1;
                                we_d    = 1'b1;
                                addr_d  = '0;
                                data_d  = BLANK_CHAR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            CLEAR: begin
                ready_d = 1'b0;
                busy_d  = 1'b1;
                if (addr_q == ADDR_LAST) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    cx_d    = '0;
                    cy_d    = '0;
                end else begin
                    we_d   = 1'b1;
                    addr_d = addr_q + 1'b1;
                    data_d = BLANK_CHAR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
        end
    end

    assign key_ready_out = ready_q;
    assign te_write_en   = we_q;
    assign te_addr       = addr_q;
    assign te_input      = data_q;
    assign cursor_x_out  = cx_q;
    assign cursor_y_out  = cy_q;
    assign busy_out      = busy_q;

endmodule
